// File: rtl/serial_add_sub.sv
`default_nettype none
// serial_add_sub: digit-serial adder/subtractor, DIGIT_W bits per clock, LSB digit first,
// Start/Busy/Done handshake with registered, held Sum/Cout/Ovf/Zero.
module serial_add_sub #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("serial_add_sub: WIDTH must be a multiple of DIGIT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT_W:0] dsum;
  logic [WIDTH-1:0] res_next;
  logic             msb_cin;

  // opA doubles as the result shift register: each digit sum enters at the top
  // as the consumed operand digit leaves at the bottom.
  assign dsum     = {1'b0, opa_q[DIGIT_W-1:0]} + {1'b0, opb_q[DIGIT_W-1:0]}
                  + {{DIGIT_W{1'b0}}, carry_q};
  assign res_next = WIDTH'({dsum[DIGIT_W-1:0], opa_q} >> DIGIT_W);
  // Carry into the MSB recovered from the MSB's sum bit and its operand bits.
  assign msb_cin  = res_next[WIDTH-1] ^ opa_q[DIGIT_W-1] ^ opb_q[DIGIT_W-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          opa_d   = a_i;
          opb_d   = sub_i ? ~b_i : b_i;
          carry_d = cin_i ^ sub_i;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = res_next;
        opb_d   = opb_q >> DIGIT_W;
        carry_d = dsum[DIGIT_W];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_next;
          cout_d  = dsum[DIGIT_W];
          ovf_d   = msb_cin ^ dsum[DIGIT_W];
          zero_d  = ~|res_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// tb_serial_add_sub: runs configurations 8/1, 8/2, 8/8, 16/4 and 8/4 side by side and
// compares every result against an integer-arithmetic model.
module tb_serial_add_sub;

  localparam int NI = 5;

  function automatic int w_of(input int i);
    case (i)
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int d_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] start = '0;
  logic [15:0]   a = '0;
  logic [15:0]   b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;

  logic        busy_v [NI];
  logic        done_v [NI];
  logic        cout_v [NI];
  logic        ovf_v  [NI];
  logic        zero_v [NI];
  logic [15:0] sum_v  [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = w_of(gi);
    logic [W-1:0] s;
    logic bs, dn, co, ov, zr;
    serial_add_sub #(.WIDTH(W), .DIGIT_W(d_of(gi))) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .start_i(start[gi]),
      .a_i    (a[W-1:0]),
      .b_i    (b[W-1:0]),
      .cin_i  (cin),
      .sub_i  (sub),
      .busy_o (bs),
      .done_o (dn),
      .sum_o  (s),
      .cout_o (co),
      .ovf_o  (ov),
      .zero_o (zr)
    );
    assign sum_v[gi]  = 16'(s);
    assign busy_v[gi] = bs;
    assign done_v[gi] = dn;
    assign cout_v[gi] = co;
    assign ovf_v[gi]  = ov;
    assign zero_v[gi] = zr;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] prev_sum  [NI];
  logic        prev_cout [NI];
  logic        prev_ovf  [NI];
  logic        prev_zero [NI];
  logic [15:0] res_sum   [NI];
  logic        res_cout  [NI];
  logic        res_ovf   [NI];
  logic        res_zero  [NI];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {zero, ovf, cout, sum} from plain integer arithmetic on the operands.
  function automatic logic [18:0] model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                        input logic tcin, input logic tsub);
    longint m  = longint'(1) << w;
    longint ua = longint'(ta) & (m - 1);
    longint ub = longint'(tb) & (m - 1);
    longint ci = tcin ? 1 : 0;
    longint r, sa, sb, sr;
    logic [15:0] s;
    logic c, o;
    r  = tsub ? (ua - ub - ci) : (ua + ub + ci);
    s  = 16'(r & (m - 1));
    c  = tsub ? (r >= 0) : (r >= m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = tsub ? (sa - sb - ci) : (sa + sb + ci);
    o  = (sr > m / 2 - 1) || (sr < -(m / 2));
    return {(s == 16'h0), o, c, s};
  endfunction

  task automatic set_prev_zero();
    for (int i = 0; i < NI; i++) begin
      prev_sum[i] = '0; prev_cout[i] = 1'b0; prev_ovf[i] = 1'b0; prev_zero[i] = 1'b0;
    end
  endtask

  task automatic run_op(input logic [NI-1:0] mask, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub);
    logic [18:0] e [NI];
    bit seen [NI];
    bit held [NI];
    bit pulse_ok [NI];
    int busyc [NI];
    int lat [NI];
    for (int i = 0; i < NI; i++) begin
      e[i] = model(w_of(i), ta, tb, tcin, tsub);
      seen[i] = 1'b0; held[i] = 1'b1; pulse_ok[i] = 1'b1; busyc[i] = 0; lat[i] = -1;
    end
    a = ta; b = tb; cin = tcin; sub = tsub; start = mask;
    @(posedge clk); #1;
    start = '0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < NI; i++) begin
        if (mask[i]) begin
          if (!seen[i]) begin
            if (busy_v[i]) busyc[i]++;
            if (done_v[i]) begin
              seen[i] = 1'b1; lat[i] = t;
              res_sum[i] = sum_v[i]; res_cout[i] = cout_v[i];
              res_ovf[i] = ovf_v[i]; res_zero[i] = zero_v[i];
            end else if (sum_v[i] !== prev_sum[i] || cout_v[i] !== prev_cout[i] ||
                         ovf_v[i] !== prev_ovf[i] || zero_v[i] !== prev_zero[i]) begin
              held[i] = 1'b0;
            end
          end else if (t == lat[i] + 1 && done_v[i]) begin
            pulse_ok[i] = 1'b0;
          end
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      if (mask[i]) begin
        chk($sformatf("c%0d_done_seen", i), 32'(seen[i]), 32'd1);
        if (seen[i]) begin
          chk($sformatf("c%0d_latency", i), lat[i], w_of(i) / d_of(i));
          chk($sformatf("c%0d_busy_cycles", i), busyc[i], w_of(i) / d_of(i));
          chk($sformatf("c%0d_hold", i), 32'(held[i]), 32'd1);
          chk($sformatf("c%0d_done_pulse", i), 32'(pulse_ok[i]), 32'd1);
          chk($sformatf("c%0d_sum", i), res_sum[i], e[i][15:0]);
          chk($sformatf("c%0d_cout", i), res_cout[i], e[i][16]);
          chk($sformatf("c%0d_ovf", i), res_ovf[i], e[i][17]);
          chk($sformatf("c%0d_zero", i), res_zero[i], e[i][18]);
        end
        prev_sum[i] = e[i][15:0]; prev_cout[i] = e[i][16];
        prev_ovf[i] = e[i][17];   prev_zero[i] = e[i][18];
      end
    end
  endtask

  logic [28:0] dv [6];

  initial begin
    logic [7:0] ta8, tb8, es;
    logic tc, ts, ec, eo, ez;
    int first, second;
    logic [7:0] s1, s2;
    logic c1, c2, o2;
    bit no_done;

    dv[0] = {8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0};
    dv[1] = {8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    dv[2] = {8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    dv[3] = {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    dv[4] = {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    dv[5] = {8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    set_prev_zero();

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("c%0d_reset_outputs", i),
          {11'h0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], zero_v[i], sum_v[i]}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed 8-bit results
    for (int k = 0; k < 6; k++) begin
      {ta8, tb8, tc, ts, es, ec, eo, ez} = dv[k];
      run_op('1, {8'h00, ta8}, {8'h00, tb8}, tc, ts);
      chk($sformatf("dir%0d_sum", k), res_sum[0], {8'h00, es});
      chk($sformatf("dir%0d_flags", k), {res_cout[0], res_ovf[0], res_zero[0]}, {ec, eo, ez});
    end
    run_op('1, 16'h007F, 16'h0001, 1'b0, 1'b0);
    chk("w8d4_sum", res_sum[4], 16'h0080);
    chk("w8d4_ovf_cout", {res_ovf[4], res_cout[4]}, 2'b10);
    run_op('1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("w16d4_sum", res_sum[3], 16'h0000);
    chk("w16d4_cout", res_cout[3], 1'b1);

    // Handshake: mid-run Start ignored, Start in DONE accepted back-to-back
    first = -1; second = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0; o2 = 1'b0;
    a = 16'h0012; b = 16'h0034; cin = 1'b0; sub = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int t = 0; t < 30; t++) begin
      start[0] = (t == 3);
      if (t == 3) begin a = 16'h00FF; b = 16'h00FF; cin = 1'b1; sub = 1'b1; end
      if (done_v[0]) begin
        if (first < 0) begin
          first = t; s1 = sum_v[0][7:0]; c1 = cout_v[0];
          start[0] = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b1;
        end else if (second < 0) begin
          second = t; s2 = sum_v[0][7:0]; c2 = cout_v[0]; o2 = ovf_v[0];
        end
      end
      @(posedge clk); #1;
    end
    start[0] = 1'b0;
    chk("hs_first_latency", first, 8);
    chk("hs_first_sum", {c1, s1}, {1'b0, 8'h46});
    chk("hs_done_spacing", second - first, 9);
    chk("hs_second_result", {o2, c2, s2}, {1'b0, 1'b0, 8'hFF});
    prev_sum[0] = 16'h00FF; prev_cout[0] = 1'b0; prev_ovf[0] = 1'b0; prev_zero[0] = 1'b0;

    // Asynchronous reset in the middle of a run
    a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0; start = '1;
    @(posedge clk); #1;
    start = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("c%0d_async_reset", i),
          {11'h0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], zero_v[i], sum_v[i]}, 32'h0);
    no_done = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (t == 2) rst_n = 1'b1;
      for (int i = 0; i < NI; i++) if (done_v[i]) no_done = 1'b0;
    end
    chk("no_done_after_abort", 32'(no_done), 32'd1);
    set_prev_zero();

    for (int n = 0; n < 1000; n++)
      run_op('1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
